trap_ctrl: RTL

Machine-mode trap sequencer that sits between the pipeline stages and the CSR file. It arbitrates same-cycle exceptions from IF/ID/EX, `mret`, and pending interrupts, then drains or stalls the pipeline as needed. It issues a one-cycle commit pulse (trap or `mret`) to the CSR file together with stage flushes, then holds a fetch redirect until the fetch unit accepts it.

---
 rtl/trap_ctrl_if.sv | 70 +++++++
 rtl/trap_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Bundle of pipeline event, CSR, commit and redirect signals around the
// machine-mode trap sequencer. The sequencer uses the slave modport; the
// surrounding pipeline/CSR environment uses the master modport.
interface trap_ctrl_if;
    logic        if_exc_vld_i;
    logic        id_exc_vld_i;
    logic        ex_exc_vld_i;
    logic [4:0]  if_exc_cause_i;
    logic [4:0]  id_exc_cause_i;
    logic [4:0]  ex_exc_cause_i;
    logic [31:0] if_exc_tval_i;
    logic [31:0] id_exc_tval_i;
    logic [31:0] ex_exc_tval_i;
    logic [31:0] if_pc_i;
    logic [31:0] id_pc_i;
    logic [31:0] ex_pc_i;
    logic        id_valid_i;
    logic [31:0] fetch_pc_i;
    logic        id_mret_i;
    logic        ex_busy_i;
    logic        irq_soft_i;
    logic        irq_timer_i;
    logic        irq_ext_i;
    logic        csr_gie_i;
    logic [2:0]  csr_irq_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic        trap_vld_o;
    logic        trap_irq_o;
    logic [4:0]  trap_cause_o;
    logic [31:0] trap_epc_o;
    logic [31:0] trap_tval_o;
    logic        mret_vld_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        flush_ex_o;
    logic        stall_o;
    logic        redirect_vld_o;
    logic [31:0] redirect_addr_o;
    logic        redirect_rdy_i;
    logic        busy_o;

    modport slave (
        input  if_exc_vld_i, id_exc_vld_i, ex_exc_vld_i,
        input  if_exc_cause_i, id_exc_cause_i, ex_exc_cause_i,
        input  if_exc_tval_i, id_exc_tval_i, ex_exc_tval_i,
        input  if_pc_i, id_pc_i, ex_pc_i, id_valid_i, fetch_pc_i,
        input  id_mret_i, ex_busy_i,
        input  irq_soft_i, irq_timer_i, irq_ext_i,
        input  csr_gie_i, csr_irq_en_i, csr_mtvec_i, csr_mepc_i,
        input  redirect_rdy_i,
        output trap_vld_o, trap_irq_o, trap_cause_o, trap_epc_o, trap_tval_o,
        output mret_vld_o, flush_if_o, flush_id_o, flush_ex_o,
        output stall_o, redirect_vld_o, redirect_addr_o, busy_o
    );

    modport master (
        output if_exc_vld_i, id_exc_vld_i, ex_exc_vld_i,
        output if_exc_cause_i, id_exc_cause_i, ex_exc_cause_i,
        output if_exc_tval_i, id_exc_tval_i, ex_exc_tval_i,
        output if_pc_i, id_pc_i, ex_pc_i, id_valid_i, fetch_pc_i,
        output id_mret_i, ex_busy_i,
        output irq_soft_i, irq_timer_i, irq_ext_i,
        output csr_gie_i, csr_irq_en_i, csr_mtvec_i, csr_mepc_i,
        output redirect_rdy_i,
        input  trap_vld_o, trap_irq_o, trap_cause_o, trap_epc_o, trap_tval_o,
        input  mret_vld_o, flush_if_o, flush_id_o, flush_ex_o,
        input  stall_o, redirect_vld_o, redirect_addr_o, busy_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Arbitrates stage exceptions, mret and
// interrupts, drains EX before taking an interrupt, emits a one-cycle commit
// pulse with stage flushes, then holds a fetch redirect until accepted.
module trap_ctrl (
    input  logic       clk_i,
    input  logic       rst_ni,
    trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_EXC  = 2'd0,
        SRC_IRQ  = 2'd1,
        SRC_MRET = 2'd2
    } src_e;

    localparam logic [4:0] CAUSE_IRQ_SOFT  = 5'd3;
    localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
    localparam logic [4:0] CAUSE_IRQ_EXT   = 5'd11;

    // Interrupt cause from the enabled pending lines {ext, timer, soft};
    // external beats software beats timer.
    function automatic logic [4:0] irq_cause(input logic [2:0] lines);
        logic [4:0] cause;
        if (lines[2]) begin
            cause = CAUSE_IRQ_EXT;
        end else if (lines[0]) begin
            cause = CAUSE_IRQ_SOFT;
        end else begin
            cause = CAUSE_IRQ_TIMER;
        end
        return cause;
    endfunction

    state_e      state_r;
    src_e        src_r;
    logic        trap_vld_r;
    logic        trap_irq_r;
    logic [4:0]  trap_cause_r;
    logic [31:0] trap_epc_r;
    logic [31:0] trap_tval_r;
    logic        mret_vld_r;
    logic        flush_if_r;
    logic        flush_id_r;
    logic        flush_ex_r;
    logic        stall_r;
    logic        redirect_vld_r;
    logic [31:0] redirect_addr_r;
    logic        busy_r;

    logic [2:0]  irq_lines_s;
    logic        irq_pend_s;
    logic [4:0]  irq_cause_s;
    logic        sel_vld_s;
    logic        sel_mret_s;
    logic [4:0]  sel_cause_s;
    logic [31:0] sel_tval_s;
    logic [31:0] sel_epc_s;
    logic [2:0]  sel_flush_s;
    logic [31:0] mtvec_base_s;
    logic [31:0] redirect_tgt_s;

    // Pending interrupt term: global enable and any enabled, asserted line.
    always_comb begin
        irq_lines_s = {bus.irq_ext_i, bus.irq_timer_i, bus.irq_soft_i} & bus.csr_irq_en_i;
        irq_pend_s  = bus.csr_gie_i & (|irq_lines_s);
        irq_cause_s = irq_cause(irq_lines_s);
    end

    // Synchronous-event selection for IDLE: EX > ID > IF > mret. Flush vector
    // is {ex, id, if}.
    always_comb begin
        sel_vld_s   = 1'b0;
        sel_mret_s  = 1'b0;
        sel_cause_s = 5'd0;
        sel_tval_s  = 32'd0;
        sel_epc_s   = 32'd0;
        sel_flush_s = 3'b000;
        if (bus.ex_exc_vld_i) begin
            sel_vld_s   = 1'b1;
            sel_cause_s = bus.ex_exc_cause_i;
            sel_tval_s  = bus.ex_exc_tval_i;
            sel_epc_s   = bus.ex_pc_i;
            sel_flush_s = 3'b111;
        end else if (bus.id_exc_vld_i) begin
            sel_vld_s   = 1'b1;
            sel_cause_s = bus.id_exc_cause_i;
            sel_tval_s  = bus.id_exc_tval_i;
            sel_epc_s   = bus.id_pc_i;
            sel_flush_s = 3'b011;
        end else if (bus.if_exc_vld_i) begin
            sel_vld_s   = 1'b1;
            sel_cause_s = bus.if_exc_cause_i;
            sel_tval_s  = bus.if_exc_tval_i;
            sel_epc_s   = bus.if_pc_i;
            sel_flush_s = 3'b001;
        end else if (bus.id_mret_i) begin
            sel_vld_s   = 1'b1;
            sel_mret_s  = 1'b1;
            sel_flush_s = 3'b011;
        end else begin
            sel_vld_s   = 1'b0;
        end
    end

    // Redirect target evaluated during COMMIT from the live mtvec/mepc.
    always_comb begin
        mtvec_base_s   = bus.csr_mtvec_i & 32'hFFFF_FFFC;
        redirect_tgt_s = mtvec_base_s;
        case (src_r)
            SRC_EXC: begin
                redirect_tgt_s = mtvec_base_s;
            end
            SRC_IRQ: begin
                if (bus.csr_mtvec_i[1:0] == 2'b01) begin
                    redirect_tgt_s = mtvec_base_s + {25'd0, trap_cause_r, 2'b00};
                end else begin
                    redirect_tgt_s = mtvec_base_s;
                end
            end
            SRC_MRET: begin
                redirect_tgt_s = bus.csr_mepc_i;
            end
            default: begin
                redirect_tgt_s = mtvec_base_s;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r         <= ST_IDLE;
            src_r           <= SRC_EXC;
            trap_vld_r      <= 1'b0;
            trap_irq_r      <= 1'b0;
            trap_cause_r    <= 5'd0;
            trap_epc_r      <= 32'd0;
            trap_tval_r     <= 32'd0;
            mret_vld_r      <= 1'b0;
            flush_if_r      <= 1'b0;
            flush_id_r      <= 1'b0;
            flush_ex_r      <= 1'b0;
            stall_r         <= 1'b0;
            redirect_vld_r  <= 1'b0;
            redirect_addr_r <= 32'd0;
            busy_r          <= 1'b0;
        end else begin
            trap_vld_r <= 1'b0;
            mret_vld_r <= 1'b0;
            flush_if_r <= 1'b0;
            flush_id_r <= 1'b0;
            flush_ex_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_vld_s) begin
                        state_r <= ST_COMMIT;
                        busy_r  <= 1'b1;
                        {flush_ex_r, flush_id_r, flush_if_r} <= sel_flush_s;
                        if (sel_mret_s) begin
                            src_r      <= SRC_MRET;
                            mret_vld_r <= 1'b1;
                        end else begin
                            src_r        <= SRC_EXC;
                            trap_vld_r   <= 1'b1;
                            trap_irq_r   <= 1'b0;
                            trap_cause_r <= sel_cause_s;
                            trap_epc_r   <= sel_epc_s;
                            trap_tval_r  <= sel_tval_s;
                        end
                    end else if (irq_pend_s) begin
                        state_r <= ST_DRAIN;
                        stall_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.ex_exc_vld_i) begin
                        // A late EX fault preempts the interrupt being drained.
                        state_r      <= ST_COMMIT;
                        stall_r      <= 1'b0;
                        src_r        <= SRC_EXC;
                        trap_vld_r   <= 1'b1;
                        trap_irq_r   <= 1'b0;
                        trap_cause_r <= bus.ex_exc_cause_i;
                        trap_epc_r   <= bus.ex_pc_i;
                        trap_tval_r  <= bus.ex_exc_tval_i;
                        flush_if_r   <= 1'b1;
                        flush_id_r   <= 1'b1;
                        flush_ex_r   <= 1'b1;
                    end else if (!irq_pend_s) begin
                        state_r <= ST_IDLE;
                        stall_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (!bus.ex_busy_i) begin
                        state_r      <= ST_COMMIT;
                        stall_r      <= 1'b0;
                        src_r        <= SRC_IRQ;
                        trap_vld_r   <= 1'b1;
                        trap_irq_r   <= 1'b1;
                        trap_cause_r <= irq_cause_s;
                        trap_epc_r   <= bus.id_valid_i ? bus.id_pc_i : bus.fetch_pc_i;
                        trap_tval_r  <= 32'd0;
                        flush_if_r   <= 1'b1;
                        flush_id_r   <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_COMMIT: begin
                    state_r         <= ST_REDIRECT;
                    redirect_addr_r <= redirect_tgt_s;
                    redirect_vld_r  <= 1'b1;
                    stall_r         <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (bus.redirect_rdy_i) begin
                        state_r        <= ST_IDLE;
                        redirect_vld_r <= 1'b0;
                        stall_r        <= 1'b0;
                        busy_r         <= 1'b0;
                    end else begin
                        state_r <= ST_REDIRECT;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    redirect_vld_r <= 1'b0;
                    stall_r        <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trap_vld_o      = trap_vld_r;
    assign bus.trap_irq_o      = trap_irq_r;
    assign bus.trap_cause_o    = trap_cause_r;
    assign bus.trap_epc_o      = trap_epc_r;
    assign bus.trap_tval_o     = trap_tval_r;
    assign bus.mret_vld_o      = mret_vld_r;
    assign bus.flush_if_o      = flush_if_r;
    assign bus.flush_id_o      = flush_id_r;
    assign bus.flush_ex_o      = flush_ex_r;
    assign bus.stall_o         = stall_r;
    assign bus.redirect_vld_o  = redirect_vld_r;
    assign bus.redirect_addr_o = redirect_addr_r;
    assign bus.busy_o          = busy_r;

endmodule
